aes_decrypt: RTL

- Iterative AES inverse cipher (FIPS-197 InvCipher) processing one round per cycle; companion of the encrypt core.
- Shares the same round-key store interface, but walks the key schedule in reverse: address Nr down to 0.
- Includes the combinational InvShiftRows, InvSubBytes (inverse S-box) and InvMixColumns logic, plus AddRoundKey.
- Runtime key size selected by key_len; 128-bit ciphertext in, 128-bit plaintext out.

---
 rtl/aes_decrypt_if.sv | 25 ++
 rtl/aes_decrypt.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt_if.sv
// Host and round-key store signals of the iterative AES inverse cipher.
interface aes_decrypt_if;
    localparam int unsigned BLK_W  = 128;
    localparam int unsigned ADDR_W = 4;

    logic              start;
    logic [1:0]        key_len;
    logic [BLK_W-1:0]  ciphertext;
    logic [BLK_W-1:0]  subkey;
    logic              subkey_valid;
    logic [ADDR_W-1:0] subkey_addr;
    logic [BLK_W-1:0]  plaintext;
    logic              ready;
    logic              busy;

    modport slave (
        input  start, key_len, ciphertext, subkey, subkey_valid,
        output subkey_addr, plaintext, ready, busy
    );

    modport master (
        output start, key_len, ciphertext, subkey, subkey_valid,
        input  subkey_addr, plaintext, ready, busy
    );
endinterface

// File: rtl/aes_decrypt.sv
// Iterative AES inverse cipher: one round per cycle, round keys fetched Nr down to 0.
module aes_decrypt (
    input logic         clk,
    input logic         reset,
    aes_decrypt_if.slave bus
);
    localparam int unsigned BLK_W  = 128;
    localparam int unsigned ADDR_W = 4;

    typedef enum logic [1:0] {IDLE, LOAD, ROUND} state_t;

    state_t            fsm, fsm_n;
    logic [BLK_W-1:0]  blk, blk_n;
    logic [BLK_W-1:0]  ct_q, ct_n;
    logic [BLK_W-1:0]  pt_q, pt_n;
    logic [ADDR_W-1:0] rounds_left, rounds_left_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic              ready_q, ready_n;
    logic              busy_q, busy_n;
    logic [ADDR_W-1:0] nr;
    logic [BLK_W-1:0]  round_t, round_mixed;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, matching the S-box definition).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = gf_mul(a, a);
        acc = sq;
        for (int i = 0; i < 6; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    // Undo the affine transform, then invert in GF(2^8).
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    function automatic logic [BLK_W-1:0] inv_shift_sub(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[127-8*(r+4*c) -: 8] = inv_sbox(s[127-8*(r+4*((c+4-r)%4)) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [BLK_W-1:0] inv_mix_columns(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    always_comb begin
        case (bus.key_len)
            2'b01:   nr = ADDR_W'(10);
            2'b10:   nr = ADDR_W'(12);
            default: nr = ADDR_W'(14);
        endcase
    end

    assign round_t     = inv_shift_sub(blk) ^ bus.subkey;
    assign round_mixed = inv_mix_columns(round_t);

    // Next-state and datapath update; every register holds unless its state acts.
    always_comb begin
        fsm_n         = fsm;
        blk_n         = blk;
        ct_n          = ct_q;
        pt_n          = pt_q;
        rounds_left_n = rounds_left;
        addr_n        = addr_q;
        ready_n       = ready_q;
        case (fsm)
            IDLE: begin
                if (bus.start && bus.key_len != 2'b00) begin
                    ct_n          = bus.ciphertext;
                    rounds_left_n = nr;
                    addr_n        = nr;
                    ready_n       = 1'b0;
                    fsm_n         = LOAD;
                end
            end
            LOAD: begin
                if (bus.subkey_valid) begin
                    blk_n  = ct_q ^ bus.subkey;
                    addr_n = addr_q - ADDR_W'(1);
                    fsm_n  = ROUND;
                end
            end
            ROUND: begin
                if (bus.subkey_valid) begin
                    rounds_left_n = rounds_left - ADDR_W'(1);
                    addr_n        = (addr_q == '0) ? '0 : addr_q - ADDR_W'(1);
                    if (rounds_left == ADDR_W'(1)) begin
                        blk_n   = round_t;
                        pt_n    = round_t;
                        ready_n = 1'b1;
                        fsm_n   = IDLE;
                    end else begin
                        blk_n = round_mixed;
                    end
                end
            end
            default: fsm_n = IDLE;
        endcase
        busy_n = (fsm_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm         <= IDLE;
            blk         <= '0;
            ct_q        <= '0;
            pt_q        <= '0;
            rounds_left <= '0;
            addr_q      <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fsm         <= fsm_n;
            blk         <= blk_n;
            ct_q        <= ct_n;
            pt_q        <= pt_n;
            rounds_left <= rounds_left_n;
            addr_q      <= addr_n;
            ready_q     <= ready_n;
            busy_q      <= busy_n;
        end
    end

    assign bus.subkey_addr = addr_q;
    assign bus.plaintext   = pt_q;
    assign bus.ready       = ready_q;
    assign bus.busy        = busy_q;
endmodule
